axis_packer: RTL and testbench
==============================

Name: axis_packer

Overview:
- Upstream stage of the valid/ready flip-flop register in the stream datapath.
- Packs RATIO consecutive narrow beats (DSIZE bits each) into one wide beat of RATIO*DSIZE bits.
- Its registered output drives a downstream flip-flop or FIFO directly.
- s_last flushes a partially filled word. m_keep marks the lanes that hold valid data.

Parameters:
- DSIZE, 8, width of one input beat / one output lane in bits.
- RATIO, 4, input beats per output beat; legal range 2..16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous reset, active-low.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid & s_ready.
- s_data  input  DSIZE  input beat.
- s_last  input  1  beat ends a packet.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts when m_valid & m_ready.
- m_data  output  RATIO*DSIZE  packed word; lane k = bits [k*DSIZE +: DSIZE].
- m_keep  output  RATIO  per-lane valid mask.
- m_last  output  1  word ends a packet.
- partial  output  1  accumulator holds accepted beats not yet emitted (lane count != 0).

Behaviour:
- Clock and reset: one clock, clk. resetn is synchronous and active-low.
- State:
  - lane counter cnt, range 0..RATIO-1, width clog2(RATIO).
  - accumulator acc_data (RATIO-1 lanes suffice) and acc_keep.
  - output register m_data / m_keep / m_last / m_valid.
- s_ready = ~m_valid | m_ready. It is combinational from registered state and m_ready only, never from s_valid, s_data or s_last.
- Accepted beat, cnt < RATIO-1 and s_last=0:
  - s_data is written into lane cnt of acc_data.
  - acc_keep[cnt] <= 1.
  - cnt <= cnt+1.
- Completing beat (cnt == RATIO-1, or s_last=1):
  - Next edge: m_data <= acc_data with lane cnt replaced by s_data; lanes above cnt forced to 0.
  - m_keep <= acc_keep | (1<<cnt); bits above cnt are 0.
  - m_last <= s_last; m_valid <= 1.
  - cnt <= 0; acc_keep <= 0.
- Latency: m_valid rises on the edge after the completing beat is accepted.
- Throughput: one input beat per cycle while m_ready=1. A word leaves every RATIO cycles with no bubbles.
- m_valid clears on the edge where m_valid & m_ready and no completing beat is accepted that cycle.
- Simultaneous drain and complete: the output register reloads in the same edge and m_valid stays 1.
- Stall (m_valid & ~m_ready):
  - m_data, m_keep and m_last are held stable.
  - s_ready = 0, so no beats are accepted, including non-completing ones.
- Lane order: the first beat of a word goes in lane 0 (LSBs).
- Partial word (s_last with cnt < RATIO-1):
  - m_keep is contiguous from bit 0.
  - Unused lanes of m_data are 0.
- Word fill and packet end together (s_last with cnt == RATIO-1): m_keep all ones, m_last=1.
- After a word is emitted, the next accepted beat goes to lane 0.
- partial = (cnt != 0).
- Reset (resetn=0 at an edge), values on the following edge:
  - m_valid=0, m_last=0, m_keep=0, m_data=0.
  - cnt=0, acc_keep=0, hence partial=0.
  - Any partial word is discarded.
  - s_ready=1 from the cycle after reset.
- acc_data needs no reset because acc_keep gates it.
- s_data and s_last are ignored when s_valid=0.

Test Plan:
1. RATIO=4, DSIZE=8, m_ready=1. Send 0x11, 0x22, 0x33, 0x44 back-to-back, s_last=0 -> one edge after the 4th accept: m_valid=1, m_data=0x44332211, m_keep=4'b1111, m_last=0; partial high after beats 1-3 and low after the 4th.
2. Send 0xAA, then 0xBB with s_last=1 -> m_data=0x0000BBAA, m_keep=4'b0011, m_last=1. Then 0x01..0x04 -> m_data=0x04030201, m_keep=1111: the new packet restarts at lane 0.
3. Send 8 beats 0x00..0x07 with s_last on beat 8, m_ready=1 -> words 0x03020100 (last=0) and 0x07060504 (last=1), four cycles apart, s_ready constantly 1.
4. Backpressure: complete word 0x44332211 while m_ready=0 -> m_valid held, s_ready=0, m_data stable for 10 cycles, no beat lost. Raise m_ready with the next word's beats already waiting -> 0x44332211 drains and the next word follows with no gap or loss.
5. Accept 0x55, 0x66, then pulse resetn=0 for one cycle. Then send 0x01..0x04 -> m_valid=0 and partial=0 during reset; next output 0x04030201, keep=1111 (stale lanes discarded).
6. Random s_valid/m_ready at 50%, random s_last, RATIO=3, 2000 beats -> scoreboard matches the reference packing model exactly. AXI stability holds: while m_valid & ~m_ready, m_data, m_keep and m_last never change.

Source files
------------

// File: rtl/axis_packer.sv
// axis_packer: packs RATIO narrow input beats (DSIZE bits each) into one wide
// registered output word. s_last flushes a partial word; m_keep marks the
// lanes that carry data. Lane 0 (LSBs) always receives the first beat.
module axis_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DSIZE-1:0]       s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [RATIO*DSIZE-1:0] m_data,
  output logic [RATIO-1:0]       m_keep,
  output logic                   m_last,
  output logic                   partial
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  // Lane counter and accumulator. The top lane never needs storing: the beat
  // that lands there always completes the word and goes straight out.
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [RATIO-2:0][DSIZE-1:0]    acc_data_q, acc_data_d;
  logic [RATIO-2:0]               acc_keep_q, acc_keep_d;

  // Output register.
  logic                           m_valid_q, m_valid_d;
  logic [RATIO-1:0][DSIZE-1:0]    m_data_q, m_data_d;
  logic [RATIO-1:0]               m_keep_q, m_keep_d;
  logic                           m_last_q, m_last_d;

  // Per-lane view of the word that a completing beat would produce.
  logic [RATIO-2:0]               lane_hit;
  logic [RATIO-2:0]               lane_below;
  logic [RATIO-1:0][DSIZE-1:0]    word_data;
  logic [RATIO-1:0]               word_keep;

  logic                           accept;
  logic                           completes;

  // s_ready depends only on registered state and m_ready, never on s_valid.
  assign s_ready   = ~m_valid_q | m_ready;
  assign accept    = s_valid & s_ready;
  assign completes = accept & (s_last | (cnt_q == CNT_MAX));

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      if (gi < RATIO - 1) begin : g_stored
        assign lane_hit[gi]   = (cnt_q == CW'(gi));
        assign lane_below[gi] = (cnt_q > CW'(gi));
        // Lanes below cnt come from the accumulator, lane cnt from the
        // incoming beat, lanes above cnt are forced to zero.
        assign word_data[gi]  = lane_hit[gi]   ? s_data :
                                lane_below[gi] ? acc_data_q[gi] : '0;
        assign word_keep[gi]  = acc_keep_q[gi] | lane_hit[gi];
      end else begin : g_top
        assign word_data[gi]  = (cnt_q == CNT_MAX) ? s_data : '0;
        assign word_keep[gi]  = (cnt_q == CNT_MAX);
      end
    end
  endgenerate

  // Next-state: fill the accumulator, load the output word on completion,
  // and release the output register once drained.
  always_comb begin
    cnt_d      = cnt_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;

    if (completes) begin
      // Reload covers the simultaneous drain case: m_valid stays high.
      m_data_d   = word_data;
      m_keep_d   = word_keep;
      m_last_d   = s_last;
      m_valid_d  = 1'b1;
      cnt_d      = '0;
      acc_keep_d = '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (lane_hit[k]) begin
            acc_data_d[k] = s_data;
            acc_keep_d[k] = 1'b1;
          end
        end
        cnt_d = cnt_q + CW'(1);
      end
      if (m_valid_q && m_ready) begin
        m_valid_d = 1'b0;
      end
    end
  end

  // Control and output state, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q      <= '0;
      acc_keep_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_keep_q <= acc_keep_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
    end
  end

  // Accumulator data is gated by acc_keep, so it carries no reset.
  always_ff @(posedge clk) begin
    acc_data_q <= acc_data_d;
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign partial = (cnt_q != '0);

endmodule

// File: tb/tb_axis_packer.sv
// tb_axis_packer: directed vector table and hand sequences on a RATIO=4
// packer, random traffic on a RATIO=3 packer, both watched by a scoreboard.
module tb_axis_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        sv4, sr4, sl4, mv4, mr4, ml4, pt4;
  logic [7:0]  sd4;
  logic [31:0] md4;
  logic [3:0]  mk4;

  logic        sv3, sr3, sl3, mv3, mr3, ml3, pt3;
  logic [7:0]  sd3;
  logic [23:0] md3;
  logic [2:0]  mk3;

  axis_packer #(.DSIZE(8), .RATIO(4)) u4 (
    .clk(clk), .resetn(resetn),
    .s_valid(sv4), .s_ready(sr4), .s_data(sd4), .s_last(sl4),
    .m_valid(mv4), .m_ready(mr4), .m_data(md4), .m_keep(mk4),
    .m_last(ml4), .partial(pt4)
  );

  axis_packer #(.DSIZE(8), .RATIO(3)) u3 (
    .clk(clk), .resetn(resetn),
    .s_valid(sv3), .s_ready(sr3), .s_data(sd3), .s_last(sl3),
    .m_valid(mv3), .m_ready(mr3), .m_data(md3), .m_keep(mk3),
    .m_last(ml3), .partial(pt3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference packing model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t       q4[$];
  word_t       q3[$];
  logic [31:0] acc_d[2];
  logic [3:0]  acc_k[2];
  int          mcnt[2];
  bit          stall_prev[2];
  logic [31:0] prev_d[2];
  logic [3:0]  prev_k[2];
  logic        prev_l[2];
  int          beats3 = 0;

  // Called on the falling edge: inputs and outputs shown here are what the
  // next rising edge will act on.
  task automatic mon(input int id, input int ratio, input logic rn,
                     input logic sv, input logic sr, input logic [7:0] sd, input logic sl,
                     input logic mv, input logic mr, input logic [31:0] md,
                     input logic [3:0] mk, input logic ml, input logic pt);
    word_t w;
    int    qs;
    qs = (id == 0) ? q4.size() : q3.size();
    chk($sformatf("sb%0d.s_ready", id), {31'b0, sr}, {31'b0, (!mv || mr)});
    chk($sformatf("sb%0d.partial", id), {31'b0, pt}, {31'b0, (mcnt[id] != 0)});
    chk($sformatf("sb%0d.m_valid", id), {31'b0, mv}, {31'b0, (qs != 0)});
    if (stall_prev[id]) begin
      chk($sformatf("sb%0d.stall_data", id), md, prev_d[id]);
      chk($sformatf("sb%0d.stall_keep", id), {28'b0, mk}, {28'b0, prev_k[id]});
      chk($sformatf("sb%0d.stall_last", id), {31'b0, ml}, {31'b0, prev_l[id]});
    end
    if (!rn) begin
      if (id == 0) q4.delete(); else q3.delete();
      mcnt[id] = 0; acc_d[id] = '0; acc_k[id] = '0; stall_prev[id] = 1'b0;
      return;
    end
    if (mv && mr && qs != 0) begin
      w = (id == 0) ? q4.pop_front() : q3.pop_front();
      chk($sformatf("sb%0d.word_data", id), md, w.d);
      chk($sformatf("sb%0d.word_keep", id), {28'b0, mk}, {28'b0, w.k});
      chk($sformatf("sb%0d.word_last", id), {31'b0, ml}, {31'b0, w.l});
    end
    if (sv && sr) begin
      acc_d[id] = acc_d[id] | (32'(sd) << (8 * mcnt[id]));
      acc_k[id] = acc_k[id] | (4'(1) << mcnt[id]);
      if (id == 1) beats3++;
      if (sl || mcnt[id] == ratio - 1) begin
        w.d = acc_d[id]; w.k = acc_k[id]; w.l = sl;
        if (id == 0) q4.push_back(w); else q3.push_back(w);
        mcnt[id] = 0; acc_d[id] = '0; acc_k[id] = '0;
      end else begin
        mcnt[id]++;
      end
    end
    stall_prev[id] = mv && !mr;
    prev_d[id] = md; prev_k[id] = mk; prev_l[id] = ml;
  endtask

  always @(negedge clk) begin
    mon(0, 4, resetn, sv4, sr4, sd4, sl4, mv4, mr4, md4, mk4, ml4, pt4);
    mon(1, 3, resetn, sv3, sr3, sd3, sl3, mv3, mr3, {8'h00, md3}, {1'b0, mk3}, ml3, pt3);
  end

  // ---------------- directed vector table (RATIO=4) ----------------
  typedef struct {
    bit          rn;
    bit          sv;
    logic [7:0]  sd;
    bit          sl;
    bit          mr;
    bit          mv;
    bit          chkd;
    logic [31:0] md;
    logic [3:0]  mk;
    bit          ml;
    bit          pt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t vv(bit rn, bit sv, logic [7:0] sd, bit sl, bit mr,
                              bit mv, bit chkd, logic [31:0] md, logic [3:0] mk,
                              bit ml, bit pt);
    vec_t t;
    t.rn = rn; t.sv = sv; t.sd = sd; t.sl = sl; t.mr = mr;
    t.mv = mv; t.chkd = chkd; t.md = md; t.mk = mk; t.ml = ml; t.pt = pt;
    return t;
  endfunction

  task automatic drive4(input bit rn, input bit v, input logic [7:0] d, input bit l, input bit mr);
    resetn = rn; sv4 = v; sd4 = d; sl4 = l; mr4 = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b4[4];
    int cyc;

    resetn = 1'b0;
    sv4 = 1'b0; sd4 = '0; sl4 = 1'b0; mr4 = 1'b1;
    sv3 = 1'b0; sd3 = '0; sl3 = 1'b0; mr3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      acc_d[i] = '0; acc_k[i] = '0; mcnt[i] = 0; stall_prev[i] = 1'b0;
      prev_d[i] = '0; prev_k[i] = '0; prev_l[i] = 1'b0;
    end

    //            rn sv  sd    sl mr  mv chk md            mk    ml pt
    tbl[0]  = vv(0, 0, 8'h00, 0, 1, 0, 1, 32'h00000000, 4'h0, 0, 0);
    tbl[1]  = vv(1, 1, 8'h11, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[2]  = vv(1, 1, 8'h22, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[3]  = vv(1, 1, 8'h33, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[4]  = vv(1, 1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0, 0);
    tbl[5]  = vv(1, 1, 8'hAA, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[6]  = vv(1, 1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1, 0);
    tbl[7]  = vv(1, 1, 8'h01, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[8]  = vv(1, 1, 8'h02, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[9]  = vv(1, 1, 8'h03, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[10] = vv(1, 1, 8'h04, 0, 1, 1, 1, 32'h04030201, 4'hF, 0, 0);
    tbl[11] = vv(1, 1, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[12] = vv(1, 1, 8'h01, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[13] = vv(1, 1, 8'h02, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[14] = vv(1, 1, 8'h03, 0, 1, 1, 1, 32'h03020100, 4'hF, 0, 0);
    tbl[15] = vv(1, 1, 8'h04, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[16] = vv(1, 1, 8'h05, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[17] = vv(1, 1, 8'h06, 0, 1, 0, 0, 32'h0,        4'h0, 0, 1);
    tbl[18] = vv(1, 1, 8'h07, 1, 1, 1, 1, 32'h07060504, 4'hF, 1, 0);
    tbl[19] = vv(1, 0, 8'h00, 0, 1, 0, 0, 32'h0,        4'h0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      drive4(tbl[i].rn, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
      chk($sformatf("vec%0d.m_valid", i), {31'b0, mv4}, {31'b0, tbl[i].mv});
      chk($sformatf("vec%0d.partial", i), {31'b0, pt4}, {31'b0, tbl[i].pt});
      if (tbl[i].chkd) begin
        chk($sformatf("vec%0d.m_data", i), md4, tbl[i].md);
        chk($sformatf("vec%0d.m_keep", i), {28'b0, mk4}, {28'b0, tbl[i].mk});
        chk($sformatf("vec%0d.m_last", i), {31'b0, ml4}, {31'b0, tbl[i].ml});
      end
      $display("[TB] vec %0d: sv=%0b sd=%02h sl=%0b mr=%0b -> mv=%0b md=%08h mk=%0h ml=%0b pt=%0b",
               i, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr, mv4, md4, mk4, ml4, pt4);
    end

    // Backpressure: complete a word with m_ready low, hold it for 10 cycles
    // with the next beat waiting, then release.
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
    for (int i = 0; i < 4; i++) drive4(1, 1, b4[i], 0, 0);
    chk("bp.load_valid", {31'b0, mv4}, 32'd1);
    chk("bp.load_data", md4, 32'h44332211);
    for (int i = 0; i < 10; i++) begin
      drive4(1, 1, 8'h55, 0, 0);
      chk("bp.hold_valid", {31'b0, mv4}, 32'd1);
      chk("bp.hold_data", md4, 32'h44332211);
      chk("bp.hold_sready", {31'b0, sr4}, 32'd0);
      chk("bp.hold_partial", {31'b0, pt4}, 32'd0);
    end
    $display("[TB] backpressure: held md=%08h for 10 cycles", md4);
    b4[0] = 8'h55; b4[1] = 8'h66; b4[2] = 8'h77; b4[3] = 8'h88;
    drive4(1, 1, b4[0], 0, 1);
    chk("bp.drain_valid", {31'b0, mv4}, 32'd0);
    chk("bp.drain_partial", {31'b0, pt4}, 32'd1);
    for (int i = 1; i < 4; i++) drive4(1, 1, b4[i], 0, 1);
    chk("bp.next_valid", {31'b0, mv4}, 32'd1);
    chk("bp.next_data", md4, 32'h88776655);
    chk("bp.next_keep", {28'b0, mk4}, 32'hF);
    $display("[TB] backpressure: next word md=%08h mk=%0h", md4, mk4);
    drive4(1, 0, 8'h00, 0, 1);
    chk("bp.idle_valid", {31'b0, mv4}, 32'd0);

    // Reset in the middle of a partial word discards it.
    drive4(1, 1, 8'h55, 0, 1);
    drive4(1, 1, 8'h66, 0, 1);
    chk("rst.pre_partial", {31'b0, pt4}, 32'd1);
    drive4(0, 0, 8'h00, 0, 1);
    chk("rst.m_valid", {31'b0, mv4}, 32'd0);
    chk("rst.partial", {31'b0, pt4}, 32'd0);
    chk("rst.m_data", md4, 32'h0);
    chk("rst.m_keep", {28'b0, mk4}, 32'h0);
    chk("rst.s_ready", {31'b0, sr4}, 32'd1);
    b4[0] = 8'h01; b4[1] = 8'h02; b4[2] = 8'h03; b4[3] = 8'h04;
    for (int i = 0; i < 4; i++) drive4(1, 1, b4[i], 0, 1);
    chk("rst.after_data", md4, 32'h04030201);
    chk("rst.after_keep", {28'b0, mk4}, 32'hF);
    chk("rst.after_last", {31'b0, ml4}, 32'd0);
    $display("[TB] reset: word after reset md=%08h mk=%0h", md4, mk4);
    drive4(1, 0, 8'h00, 0, 1);

    // Random traffic on the RATIO=3 instance; the scoreboard does the checks.
    cyc = 0;
    while (beats3 < 2000 && cyc < 20000) begin
      sv3 = 1'($urandom_range(0, 1));
      sd3 = 8'($urandom);
      sl3 = ($urandom_range(0, 3) == 0);
      mr3 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand.beats_reached", {31'b0, (beats3 >= 2000)}, 32'd1);
    sv3 = 1'b0; mr3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rand.drain_valid", {31'b0, mv3}, 32'd0);
    chk("rand.sb_empty", q3.size(), 32'd0);
    $display("[TB] random: %0d beats in %0d cycles", beats3, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
